// File: rtl/contador_display_pkg.sv
// rtl/contador_display_pkg.sv - shared types, segment table and double-dabble step for contador_display
// Contents: FSM state enum, 7-segment patterns for 0-9 ({g,f,e,d,c,b,a}, active-high),
// blank pattern, digit-index constants, one double-dabble iteration helper.
package contador_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [6:0] SEG_TABLE [0:9] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [1:0] DIG_UNITS    = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    // One iteration on {scratch[11:0], binary[7:0]}: add 3 to every scratch
    // nibble >= 5, then shift the whole register left by one.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] adj;
        adj = v;
        for (int n = 0; n < 3; n++) begin
            if (adj[8 + 4*n +: 4] >= 4'd5)
                adj[8 + 4*n +: 4] = adj[8 + 4*n +: 4] + 4'd3;
        end
        return {adj[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/contador_display_if.sv
// rtl/contador_display_if.sv - load/result bus between the counter stage and contador_display
// Signals: cont_in (count to convert), load (convert request), busy (conversion running),
// bcd_valid (one-cycle result strobe), bcd_out (latched {hundreds, tens, units}).
interface contador_display_if;
    logic [7:0]  cont_in;
    logic        load;
    logic        busy;
    logic        bcd_valid;
    logic [11:0] bcd_out;

    modport master (
        output cont_in, load,
        input  busy, bcd_valid, bcd_out
    );

    modport slave (
        input  cont_in, load,
        output busy, bcd_valid, bcd_out
    );
endinterface

// File: rtl/contador_display_bin2bcd_iter.sv
// rtl/contador_display_bin2bcd_iter.sv - sequential 8-bit binary to 3-digit BCD double-dabble engine
// Ports: clk, rst (sync, active-high), load/bin_in (start request and operand),
// busy (not idle), done (high during the DONE cycle), bcd (current scratch value).
module bin2bcd_iter
    import contador_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [7:0]  bin_in,
    output logic        busy,
    output logic        done,
    output logic [11:0] bcd
);

    state_t      state;
    logic [19:0] sr;
    logic [2:0]  iter;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sr    <= '0;
            iter  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        sr    <= {12'd0, bin_in};
                        iter  <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sr   <= dd_step(sr);
                    iter <= iter + 3'd1;
                    if (iter == 3'd7)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = sr[19:8];

endmodule

// File: rtl/contador_display.sv
// rtl/contador_display.sv - BCD conversion of the counter value and 3-digit multiplexed 7-segment drive
// Ports: clkk, rstt (sync, active-high), bus (contador_display_if slave: cont_in, load,
// busy, bcd_valid, bcd_out), an (one-hot digit enable, [0]=units), seg ({g..a}).
module contador_display
    import contador_pkg::*;
#(
    parameter int SCAN_DIV       = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic               clkk,
    input  logic               rstt,
    contador_display_if.slave  bus,
    output logic [2:0]         an,
    output logic [6:0]         seg
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic        eng_done;
    logic [11:0] eng_bcd;

    bin2bcd_iter u_engine (
        .clk    (clkk),
        .rst    (rstt),
        .load   (bus.load),
        .bin_in (bus.cont_in),
        .busy   (bus.busy),
        .done   (eng_done),
        .bcd    (eng_bcd)
    );

    // Result latch: only moves on the DONE cycle, so the display keeps the
    // previous value while a conversion is in flight.
    always_ff @(posedge clkk) begin
        if (rstt) begin
            bus.bcd_out   <= '0;
            bus.bcd_valid <= 1'b0;
        end else begin
            bus.bcd_valid <= eng_done;
            if (eng_done)
                bus.bcd_out <= eng_bcd;
        end
    end

    logic [CNT_W-1:0] scan_cnt;
    logic [1:0]       idx;
    logic [1:0]       idx_next;
    logic [3:0]       nib;
    logic             blank;
    logic [6:0]       raw_seg;
    logic [2:0]       an_next;

    // an/seg are registered from the *next* index so both switch on the same edge.
    always_comb begin
        idx_next = idx;
        if (scan_cnt == CNT_LAST)
            idx_next = (idx == DIG_HUNDREDS) ? DIG_UNITS : idx + 2'd1;

        nib     = bus.bcd_out[3:0];
        blank   = 1'b0;
        an_next = 3'b001;
        case (idx_next)
            DIG_TENS: begin
                nib     = bus.bcd_out[7:4];
                blank   = (bus.bcd_out[11:8] == 4'd0) && (bus.bcd_out[7:4] == 4'd0);
                an_next = 3'b010;
            end
            DIG_HUNDREDS: begin
                nib     = bus.bcd_out[11:8];
                blank   = (bus.bcd_out[11:8] == 4'd0);
                an_next = 3'b100;
            end
            default: ;
        endcase

        raw_seg = (blank || nib > 4'd9) ? SEG_BLANK : SEG_TABLE[nib];
    end

    always_ff @(posedge clkk) begin
        if (rstt) begin
            scan_cnt <= '0;
            idx      <= DIG_UNITS;
            an       <= 3'b001;
            seg      <= SEG_ACTIVE_LOW ? ~SEG_TABLE[0] : SEG_TABLE[0];
        end else begin
            scan_cnt <= (scan_cnt == CNT_LAST) ? '0 : scan_cnt + 1'b1;
            idx      <= idx_next;
            an       <= an_next;
            seg      <= SEG_ACTIVE_LOW ? ~raw_seg : raw_seg;
        end
    end

endmodule

// File: tb/tb_contador_display.sv
// tb/tb_contador_display.sv - self-checking bench for contador_display (both segment polarities)
module tb_contador_display;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] an0, an1;
    logic [6:0] seg0, seg1;
    int         passed = 0;
    int         total  = 0;

    always #5 clk = ~clk;

    contador_display_if bus0 ();
    contador_display_if bus1 ();

    contador_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clkk(clk), .rstt(rst), .bus(bus0.slave), .an(an0), .seg(seg0)
    );
    contador_display #(.SCAN_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .clkk(clk), .rstt(rst), .bus(bus1.slave), .an(an1), .seg(seg1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic [7:0] v, input logic ld);
        bus0.cont_in = v; bus1.cont_in = v;
        bus0.load = ld;   bus1.load = ld;
    endtask

    function automatic int pat(input int d);
        case (d)
            0: return 'h3F; 1: return 'h06; 2: return 'h5B; 3: return 'h4F; 4: return 'h66;
            5: return 'h6D; 6: return 'h7D; 7: return 'h07; 8: return 'h7F; 9: return 'h6F;
            default: return -1;
        endcase
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
    endfunction

    // pos: 0 units, 1 tens, 2 hundreds
    function automatic int exp_seg(input int v, input int pos);
        int h, t, u;
        h = v / 100; t = (v / 10) % 10; u = v % 10;
        if (pos == 0) return pat(u);
        if (pos == 1) return (h == 0 && t == 0) ? 0 : pat(t);
        return (h == 0) ? 0 : pat(h);
    endfunction

    function automatic int onehot(input int pos);
        return 1 << pos;
    endfunction

    // Starts at a negedge; ends at the negedge after the bcd_valid edge.
    task automatic do_convert(input int v, input string tag);
        drive(8'(v), 1'b1);
        @(negedge clk);
        drive(8'(v), 1'b0);
        for (int j = 0; j < 9; j++) begin
            chk({tag, "_busy"}, int'(bus0.busy), 1);
            chk({tag, "_novalid"}, int'(bus0.bcd_valid), 0);
            @(negedge clk);
        end
        chk({tag, "_busy_end"}, int'(bus0.busy), 0);
        chk({tag, "_valid"}, int'(bus0.bcd_valid), 1);
        chk({tag, "_bcd"}, int'(bus0.bcd_out), to_bcd(v));
        chk({tag, "_bcd_al"}, int'(bus1.bcd_out), to_bcd(v));
    endtask

    task automatic check_display(input int v, input string tag);
        bit seen [3];
        int pos;
        seen = '{0, 0, 0};
        @(negedge clk);
        chk({tag, "_valid_drop"}, int'(bus0.bcd_valid), 0);
        for (int c = 0; c < 14; c++) begin
            pos = (an0 == 3'b001) ? 0 : (an0 == 3'b010) ? 1 : (an0 == 3'b100) ? 2 : -1;
            if (pos < 0) begin
                chk({tag, "_an_onehot"}, int'(an0), 1);
            end else if (!seen[pos]) begin
                seen[pos] = 1'b1;
                chk($sformatf("%s_seg%0d", tag, pos), int'(seg0), exp_seg(v, pos));
                chk($sformatf("%s_segal%0d", tag, pos), int'(seg1), (~exp_seg(v, pos)) & 'h7F);
                chk($sformatf("%s_an_al%0d", tag, pos), int'(an1), int'(an0));
            end
            @(negedge clk);
        end
        for (int p = 0; p < 3; p++)
            if (!seen[p]) chk($sformatf("%s_digit%0d_seen", tag, p), 0, 1);
    endtask

    initial begin
        int pulses;
        int v;
        drive(8'd0, 1'b0);

        // 1: reset and free-running scan
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", int'(bus0.busy), 0);
        chk("rst_valid", int'(bus0.bcd_valid), 0);
        chk("rst_bcd", int'(bus0.bcd_out), 0);
        chk("rst_an", int'(an0), 1);
        chk("rst_seg", int'(seg0), 'h3F);
        chk("rst_seg_al", int'(seg1), 'h40);
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            chk($sformatf("scan_an_%0d", i), int'(an0), onehot((i / 4) % 3));
            chk($sformatf("scan_seg_%0d", i), int'(seg0), exp_seg(0, (i / 4) % 3));
        end

        // 2: full-scale value
        do_convert(255, "c255");
        check_display(255, "d255");

        // 3: small value, leading-zero blanking in both polarities
        do_convert(7, "c7");
        check_display(7, "d7");

        // 4: load during conversion is ignored
        drive(8'd100, 1'b1);
        @(negedge clk);
        drive(8'd100, 1'b0);
        @(negedge clk);
        @(negedge clk);
        drive(8'd200, 1'b1);
        @(negedge clk);
        drive(8'd200, 1'b0);
        pulses = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus0.bcd_valid) pulses++;
            @(negedge clk);
        end
        chk("ign_pulses", pulses, 1);
        chk("ign_bcd", int'(bus0.bcd_out), 'h100);

        // 5: reset in the middle of a conversion
        drive(8'd128, 1'b1);
        @(negedge clk);
        drive(8'd128, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_an", int'(an0), 1);
        chk("abort_busy", int'(bus0.busy), 0);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus0.bcd_valid) pulses++;
            @(negedge clk);
        end
        chk("abort_pulses", pulses, 0);
        chk("abort_bcd", int'(bus0.bcd_out), 0);
        do_convert(128, "c128");
        check_display(128, "d128");

        // 6: back-to-back load accepted in the bcd_valid cycle
        do_convert(9, "c9");
        do_convert(10, "c10");
        check_display(10, "d10");

        // random values against the arithmetic model
        for (int r = 0; r < 16; r++) begin
            v = int'($urandom_range(0, 255));
            do_convert(v, $sformatf("rnd%0d", v));
            check_display(v, $sformatf("rdisp%0d", v));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/contador_display.md
Name: contador_display

Overview:
- Downstream consumer of the 8-bit up/down counter; takes its count value and drives a 3-digit multiplexed 7-segment display.
- On a load request it converts the binary count to BCD with an iterative double-dabble engine, latches the three digits, and continuously scans them onto the display.
- Leading zeros are blanked.

Parameters:
- SCAN_DIV, 4: clock cycles each digit stays enabled (legal ≥2).
- SEG_ACTIVE_LOW, 0: 1 inverts the `seg` outputs for common-anode displays; `an` polarity is unaffected.

Ports:
- clkk  in  1  system clock, rising edge.
- rstt  in  1  reset, synchronous, active-high.
- cont_in  in  8  binary count from the counter stage.
- load  in  1  request to sample `cont_in` and convert.
- busy  out  1  conversion in progress.
- bcd_valid  out  1  one-cycle pulse when `bcd_out` is updated.
- bcd_out  out  12  latched result {hundreds, tens, units}, 4 bits each.
- an  out  3  one-hot digit enable, active-high: [0]=units, [1]=tens, [2]=hundreds.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-high when SEG_ACTIVE_LOW=0.

Behaviour:
- Reset values (rstt high at a rising edge):
  - state IDLE, busy=0, bcd_valid=0, bcd_out=0x000.
  - Scan counter=0, digit index=0, an=3'b001, seg=units '0' pattern (0x3F).
- FSM states:
  - IDLE: `load`=1 at edge k → capture `cont_in` into the shift register, clear the 12-bit BCD scratch and iteration count, go to SHIFT.
  - SHIFT: edges k+1..k+8 each perform one iteration: add 3 to every scratch nibble ≥5, then shift {scratch, binary} left by 1. After the 8th iteration (edge k+8) go to DONE.
  - DONE: edge k+9 loads the scratch into `bcd_out`, sets bcd_valid=1 for exactly one cycle, returns to IDLE.
- busy = (state != IDLE). It is high for the 9 cycles after edge k.
- `load` during SHIFT/DONE is ignored: no queueing, no restart.
- `load` in the cycle bcd_valid is high (state IDLE) is accepted.
- `bcd_out` changes only at DONE; the display shows the old value during conversion.
- Range: 0..255 → BCD 0x000..0x255. Hundreds nibble never exceeds 2, and no nibble exceeds 9.
- Scanner, free-running and independent of the FSM:
  - The counter counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the digit index advances 0→1→2→0 and `an` rotates 001→010→100→001.
- seg decodes the selected nibble:
  - 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
  - Blank=0x00.
- Blanking:
  - Hundreds is blank if 0.
  - Tens is blank if hundreds=0 and tens=0.
  - Units is never blank.
- With SEG_ACTIVE_LOW=1, seg = bitwise NOT of the above (blank=0x7F).
- `an` and `seg` are registered and update together: no glitch between digits.
- Reset mid-conversion: abort, bcd_out=0, no bcd_valid pulse, scanner restarts at units.

Decomposition:
- Package contador_pkg:
  - FSM state enum {IDLE, SHIFT, DONE}.
  - 7-segment constant table for digits 0-9.
  - SEG_BLANK constant and the digit-index constants.
- Sub-module bin2bcd_iter: the sequential double-dabble engine with load/busy/valid.
- The top holds the result latch, blanking logic, scanner and segment decode.

Test Plan:
1. Reset held 2 cycles → busy=0, bcd_valid=0, bcd_out=0x000, an=001, seg=0x3F. After release, an steps 001→010→100 every 4 clocks, with seg=0x00 on tens and hundreds.
2. cont_in=255, load for one cycle at edge k → busy high edges k..k+8, bcd_valid high only after edge k+9, bcd_out=0x255. Display shows hundreds 0x5B, tens 0x6D, units 0x6D.
3. cont_in=7, load → bcd_out=0x007; units seg=0x07, tens and hundreds seg=0x00. With SEG_ACTIVE_LOW=1: units 0x78, blanks 0x7F.
4. load with cont_in=100, then load with cont_in=200 three cycles later → exactly one bcd_valid pulse, bcd_out=0x100.
5. cont_in=128, load; rstt high after the 4th iteration → no bcd_valid, bcd_out=0x000. Then load 128 → bcd_out=0x128 after 9 cycles.
6. load cont_in=9, then load cont_in=10 in the cycle bcd_valid is high → two pulses 9 cycles apart, bcd_out 0x009 then 0x010. Tens shows 0x06, units 0x3F, hundreds blank.
